// File: rtl/ifu_pc_fetch.sv
// PC generation and single-outstanding instruction fetch front end with a one-entry decode buffer.
// Optional build macro IFU_STATS_EN adds stat_fetched / stat_flushed counters.
module ifu_pc_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int unsigned INST_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [63:0]       redirect_pc,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [63:0]       req_addr,
   input  logic              resp_valid,
   input  logic [INST_W-1:0] resp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic [63:0]       inst_pc,
   output logic [1:0]        dbg_state
`ifdef IFU_STATS_EN
   ,
   output logic [63:0]       stat_fetched,
   output logic [63:0]       stat_flushed
`endif
);

   // Handshakes: a transfer happens on a posedge where valid and ready are both high;
   // valid never depends on ready, and the consumer samples the payload only on a transfer.

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [63:0]         pc_q, pc_d;
   logic                drop_q, drop_d;
   logic [INST_W-1:0]   inst_q, inst_d;
   logic [63:0]         inst_pc_q, inst_pc_d;
   logic [63:0]         redirect_aln;
   logic                req_fire;

   assign redirect_aln = {redirect_pc[63:2], 2'b00};
   assign req_fire     = (state_q == ST_REQ) && req_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_REQ: begin
            if (req_fire) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Any response ends the wait; only a clean one reaches decode.
            if (resp_valid) begin
               state_d = (drop_q || redirect_valid) ? ST_REQ : ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect_valid || inst_ready) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase
   end

   always_comb begin
      pc_d      = pc_q;
      drop_d    = drop_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      case (state_q)
         ST_REQ: begin
            if (redirect_valid) begin
               pc_d = redirect_aln;
               if (req_fire) begin
                  drop_d = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (resp_valid) begin
               drop_d = 1'b0;
               if (redirect_valid) begin
                  pc_d = redirect_aln;
               end else if (!drop_q) begin
                  inst_d    = resp_data;
                  inst_pc_d = pc_q;
               end
            end else if (redirect_valid) begin
               pc_d   = redirect_aln;
               drop_d = 1'b1;
            end
         end
         ST_HOLD: begin
            // Redirect wins over the decode handshake, so the sequential pc is not taken.
            if (redirect_valid) begin
               pc_d = redirect_aln;
            end else if (inst_ready) begin
               pc_d = pc_q + 64'd4;
            end
         end
         default: begin
            drop_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         drop_q    <= 1'b0;
         inst_q    <= '0;
         inst_pc_q <= '0;
      end else begin
         pc_q      <= pc_d;
         drop_q    <= drop_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
      end
   end

   always_comb begin
      req_valid  = !rst && (state_q == ST_REQ);
      inst_valid = !rst && (state_q == ST_HOLD);
      req_addr   = pc_q;
      inst       = inst_q;
      inst_pc    = inst_pc_q;
      dbg_state  = state_q;
   end

`ifdef IFU_STATS_EN
   logic [63:0] fetched_q, fetched_d;
   logic [63:0] flushed_q, flushed_d;
   logic        fetch_ev;
   logic        flush_ev;

   assign fetch_ev = (state_q == ST_HOLD) && inst_ready && !redirect_valid;
   assign flush_ev = ((state_q == ST_WAIT) && resp_valid && (drop_q || redirect_valid)) ||
                     ((state_q == ST_HOLD) && redirect_valid);

   always_comb begin
      fetched_d = fetch_ev ? fetched_q + 64'd1 : fetched_q;
      flushed_d = flush_ev ? flushed_q + 64'd1 : flushed_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetched_q <= '0;
         flushed_q <= '0;
      end else begin
         fetched_q <= fetched_d;
         flushed_q <= flushed_d;
      end
   end

   assign stat_fetched = fetched_q;
   assign stat_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_ifu_pc_fetch.sv
// Self-checking bench for ifu_pc_fetch: directed scenarios then randomized traffic
// against a transaction-level model of the fetch front end and a simple memory.
module tb_ifu_pc_fetch;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        inst_ready = 1'b0;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [1:0]  dbg_state;
`ifdef IFU_STATS_EN
  logic [63:0] stat_fetched;
  logic [63:0] stat_flushed;
`endif

  ifu_pc_fetch #(.RESET_PC(RESET_PC), .INST_W(32)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .dbg_state(dbg_state)
`ifdef IFU_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: transaction view of the front end.
  //   m_out   : an accepted request has no response yet
  //   m_stale : that outstanding response must be thrown away
  //   m_pres  : an instruction is offered to decode (payload at exp_q[0] = {pc, data})
  logic [63:0] m_pc;
  bit          m_out, m_stale, m_pres;
  logic [95:0] exp_q[$];
  longint unsigned m_fetched, m_flushed;
  int          mem_delay;
  logic [63:0] mem_addr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hA5A5_0F0F;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC;
    m_out = 0; m_stale = 0; m_pres = 0;
    exp_q.delete();
    m_fetched = 0; m_flushed = 0;
  endtask

  task automatic model_update(input logic rv, input logic [63:0] rpc, input logic rr,
                              input logic ir, input logic rsv, input logic [31:0] rsd);
    logic [63:0] tgt;
    tgt = rpc & ~64'd3;
    if (m_pres) begin
      if (rv) begin
        m_pres = 0; void'(exp_q.pop_front()); m_pc = tgt; m_flushed++;
      end else if (ir) begin
        m_pres = 0; void'(exp_q.pop_front()); m_pc = m_pc + 64'd4; m_fetched++;
      end
    end else if (m_out) begin
      if (rsv) begin
        m_out = 0;
        if (m_stale || rv) m_flushed++;
        else begin
          m_pres = 1;
          exp_q.push_back({m_pc, rsd});
        end
        m_stale = 0;
        if (rv) m_pc = tgt;
      end else if (rv) begin
        m_stale = 1; m_pc = tgt;
      end
    end else begin
      if (rr) begin
        m_out = 1; m_stale = rv;
        mem_addr = m_pc; mem_delay = $urandom_range(0, 2);
      end
      if (rv) m_pc = tgt;
    end
  endtask

  task automatic check_outputs();
    bit idle;
    idle = !m_out && !m_pres;
    check("req_valid", 64'(req_valid), 64'(!rst && idle));
    check("inst_valid", 64'(inst_valid), 64'(!rst && m_pres));
    check("req_addr", req_addr, m_pc);
    if (m_pres && exp_q.size() > 0) begin
      check("inst", 64'(inst), 64'(exp_q[0][31:0]));
      check("inst_pc", inst_pc, exp_q[0][95:32]);
    end
`ifdef IFU_STATS_EN
    check("stat_fetched", stat_fetched, 64'(m_fetched));
    check("stat_flushed", stat_flushed, 64'(m_flushed));
`endif
  endtask

  // driver: apply one cycle of inputs (called just after a negedge)
  task automatic step(input logic rv, input logic [63:0] rpc, input logic rr,
                      input logic ir, input logic rsv, input logic [31:0] rsd);
    rst = 1'b0;
    redirect_valid = rv; redirect_pc = rpc;
    req_ready = rr; inst_ready = ir;
    resp_valid = rsv; resp_data = rsd;
    @(posedge clk);
    model_update(rv, rpc, rr, ir, rsv, rsd);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b1; redirect_pc = {$urandom, $urandom};
    resp_valid = 1'b1; req_ready = 1'b1; inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    check_outputs();
    check("rst_req_addr", req_addr, RESET_PC);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);
    rst = 1'b0; redirect_valid = 1'b0; resp_valid = 1'b0;
    req_ready = 1'b0; inst_ready = 1'b0;
    #1;
  endtask

  function automatic logic [63:0] rand_target();
    case ($urandom_range(0, 3))
      0: return {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
      1: return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic rv, rr, ir, rsv;
    logic [63:0] rpc;
    logic [31:0] rsd;
    model_reset();
    @(negedge clk);
    do_reset();

    // basic fetch, 1-cycle response, decode accepts
    check("t1_req_valid", 64'(req_valid), 64'd1);
    check("t1_req_addr", req_addr, 64'h8000_0000);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0000_0013);
    check("t1_inst_valid", 64'(inst_valid), 64'd1);
    check("t1_inst", 64'(inst), 64'h13);
    check("t1_inst_pc", inst_pc, 64'h8000_0000);
    step(0, 0, 0, 1, 0, 0);
    check("t1_next_addr", req_addr, 64'h8000_0004);

    // memory back-pressure
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check("t2_req_valid", 64'(req_valid), 64'd1);
      check("t2_req_addr", req_addr, 64'h8000_0004);
    end
    step(0, 0, 1, 0, 0, 0);
    check("t2_wait", 64'(req_valid), 64'd0);
    step(0, 0, 0, 0, 1, 32'h1234_5678);
    step(0, 0, 0, 1, 0, 0);

    // redirect while waiting: response is stale
    step(0, 0, 1, 0, 0, 0);
    step(1, 64'h8000_1000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    check("t3_inst_valid", 64'(inst_valid), 64'd0);
    check("t3_req_addr", req_addr, 64'h8000_1000);

    // redirect coincident with response, misaligned target
    step(0, 0, 1, 0, 0, 0);
    step(1, 64'h8000_2002, 0, 0, 1, 32'hCAFE_0000);
    check("t4_inst_valid", 64'(inst_valid), 64'd0);
    check("t4_req_addr", req_addr, 64'h8000_2000);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h1111_1111);
    check("t4_delivered", 64'(inst), 64'h1111_1111);
    check("t4_inst_pc", inst_pc, 64'h8000_2000);
    step(0, 0, 0, 1, 0, 0);

    // redirect beats inst_ready in HOLD
    step(1, 64'h8000_0008, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h2222_2222);
    check("t5_inst_pc", inst_pc, 64'h8000_0008);
    step(1, 64'h8000_0100, 0, 1, 0, 0);
    check("t5_inst_valid", 64'(inst_valid), 64'd0);
    check("t5_req_addr", req_addr, 64'h8000_0100);

    // pc + 4 wraps at the top of the address space
    step(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h3333_3333);
    check("wrap_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 1, 0, 0);
    check("wrap_req_addr", req_addr, 64'h0);

    // reset in WAIT, stray response right after
    step(0, 0, 1, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 1, 32'h4444_4444);
    check("t6_req_valid", 64'(req_valid), 64'd1);
    check("t6_inst_valid", 64'(inst_valid), 64'd0);
    check("t6_req_addr", req_addr, 64'h8000_0000);
`ifdef IFU_STATS_EN
    check("t6_stat_fetched", stat_fetched, 64'd0);
    check("t6_stat_flushed", stat_flushed, 64'd0);
`endif

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        rv  = ($urandom_range(0, 7) == 0);
        rpc = rv ? rand_target() : {$urandom, $urandom};
        rr  = ($urandom_range(0, 3) != 0);
        ir  = ($urandom_range(0, 2) != 0);
        if (m_out) begin
          if (mem_delay == 0) begin
            rsv = 1'b1; rsd = mem_word(mem_addr);
          end else begin
            rsv = 1'b0; rsd = $urandom; mem_delay--;
          end
        end else begin
          rsv = ($urandom_range(0, 15) == 0);
          rsd = $urandom;
        end
        step(rv, rpc, rr, ir, rsv, rsd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
